// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified SRAM.
// The arbiter connects through the slave modport; the CPU/SRAM side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              instr_req_i;
    logic [ADDR_W-1:0] instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [DATA_W-1:0] instr_rdata_o;

    logic              data_req_i;
    logic              data_we_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [DATA_W-1:0] data_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data first) arbiter sharing one single-port SRAM between fetch and data,
// with a starvation guard for fetch. Optional perf counters via `define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    mem_port_arbiter_if.slave    bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]          conflict_cnt_o,
    output logic [31:0]          starve_evt_cnt_o
`endif
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       rd_pending_q, rd_pending_d;
    owner_e     rd_owner_q, rd_owner_d;

    logic starve_hit;
    logic instr_gnt;
    logic data_gnt;
    logic resp_valid;

    // Everything is gated by reset_ni so outputs read zero for the whole reset cycle,
    // including the one where stale state is still held in the registers.
    always_comb begin
        starve_hit = (starve_cnt_q == LIMIT);
        instr_gnt  = reset_ni & bus.instr_req_i & (~bus.data_req_i | starve_hit);
        data_gnt   = reset_ni & bus.data_req_i & ~instr_gnt;
        resp_valid = reset_ni & rd_pending_q;
    end

    always_comb begin
        bus.instr_gnt_o = instr_gnt;
        bus.data_gnt_o  = data_gnt;
        bus.mem_req_o   = instr_gnt | data_gnt;
        bus.mem_we_o    = data_gnt & bus.data_we_i;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (instr_gnt) begin
            bus.mem_addr_o = bus.instr_addr_i;
        end else if (data_gnt) begin
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_wdata_o = bus.data_wdata_i;
        end

        bus.instr_rvalid_o = resp_valid & (rd_owner_q == OWNER_INSTR);
        bus.data_rvalid_o  = resp_valid & (rd_owner_q == OWNER_DATA);
        bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
        bus.data_rdata_o   = bus.data_rvalid_o  ? bus.mem_rdata_i : '0;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rd_pending_d = 1'b0;
        rd_owner_d   = OWNER_INSTR;
        if (instr_gnt || !bus.instr_req_i) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
        if (data_gnt) begin
            rd_pending_d = ~bus.data_we_i;
            rd_owner_d   = OWNER_DATA;
        end else if (instr_gnt) begin
            rd_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            starve_cnt_q <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWNER_INSTR;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;
    logic [31:0] starve_evt_cnt_q;

    // A starvation event is an instr grant that only happened because the guard overrode data.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            conflict_cnt_q   <= '0;
            starve_evt_cnt_q <= '0;
        end else begin
            if (bus.instr_req_i && bus.data_req_i) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if (instr_gnt && bus.data_req_i && starve_hit) begin
                starve_evt_cnt_q <= starve_evt_cnt_q + 32'd1;
            end
        end
    end

    assign conflict_cnt_o   = reset_ni ? conflict_cnt_q   : '0;
    assign starve_evt_cnt_o = reset_ni ? starve_evt_cnt_q : '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
    logic [31:0] starve_evt_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk),
        .reset_ni(rst_n),
        .bus(bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .conflict_cnt_o(conflict_cnt),
        .starve_evt_cnt_o(starve_evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: consecutive denied fetch cycles and the outstanding read, if any.
    int          m_denied    = 0;
    bit          m_pend      = 0;
    bit          m_pend_data = 0;
    int unsigned m_conflicts = 0;
    int unsigned m_starve_ev = 0;

    logic              e_igt, e_dgt, e_mreq, e_mwe, e_irv, e_drv;
    logic [ADDR_W-1:0] e_maddr;
    logic [DATA_W-1:0] e_mwdata, e_ird, e_drd;

    task automatic model_eval();
        bit instr_wins;
        if (!rst_n) begin
            {e_igt, e_dgt, e_mreq, e_mwe, e_irv, e_drv} = '0;
            e_maddr = '0; e_mwdata = '0; e_ird = '0; e_drd = '0;
        end else begin
            instr_wins = bus.instr_req_i && (!bus.data_req_i || m_denied >= LIMIT);
            e_igt    = instr_wins;
            e_dgt    = bus.data_req_i && !instr_wins;
            e_mreq   = e_igt || e_dgt;
            e_mwe    = e_dgt && bus.data_we_i;
            e_maddr  = e_igt ? bus.instr_addr_i : (e_dgt ? bus.data_addr_i : '0);
            e_mwdata = e_dgt ? bus.data_wdata_i : '0;
            e_irv    = m_pend && !m_pend_data;
            e_drv    = m_pend && m_pend_data;
            e_ird    = e_irv ? bus.mem_rdata_i : '0;
            e_drd    = e_drv ? bus.mem_rdata_i : '0;
        end
    endtask

    task automatic model_advance();
        model_eval();
        if (!rst_n) begin
            m_denied = 0; m_pend = 0; m_pend_data = 0;
            m_conflicts = 0; m_starve_ev = 0;
        end else begin
            if (bus.instr_req_i && bus.data_req_i) m_conflicts++;
            if (e_igt && bus.data_req_i) m_starve_ev++;
            if (bus.instr_req_i && !e_igt) m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
            else m_denied = 0;
            m_pend      = e_igt || (e_dgt && !bus.data_we_i);
            m_pend_data = e_dgt;
        end
    endtask

    task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                                 input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd);
        bus.instr_req_i  = ir;
        bus.instr_addr_i = ia;
        bus.data_req_i   = dr;
        bus.data_we_i    = dw;
        bus.data_addr_i  = da;
        bus.data_wdata_i = dwd;
        bus.mem_rdata_i  = mrd;
        #1;
        model_eval();
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, $urandom, 1'b1, 1'b0, $urandom, $urandom, $urandom);
            vectors++;
            if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_req_o, bus.mem_we_o} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL reset_gnt: got %b expected 0000",
                         {bus.instr_gnt_o, bus.data_gnt_o, bus.mem_req_o, bus.mem_we_o});
            end
            vectors++;
            if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o, bus.data_rdata_o,
                 bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_resp: got rv=%b%b rd=%h/%h maddr=%h expected all 0",
                         bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o,
                         bus.data_rdata_o, bus.mem_addr_o);
            end
            step();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_instr_read();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
        vectors++;
        if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_we_o} !== 3'b100 || bus.mem_addr_o !== 32'h100) begin
            miscompares++;
            $display("[TB] FAIL instr_read_grant: got gnt=%b%b we=%b addr=%h expected 10 0 00000100",
                     bus.instr_gnt_o, bus.data_gnt_o, bus.mem_we_o, bus.mem_addr_o);
        end
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
        vectors++;
        if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'hDEADBEEF ||
            bus.data_rvalid_o !== 1'b0 || bus.data_rdata_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL instr_read_resp: got irv=%b ird=%h drv=%b drd=%h expected 1 deadbeef 0 0",
                     bus.instr_rvalid_o, bus.instr_rdata_o, bus.data_rvalid_o, bus.data_rdata_o);
        end
        step();
    endtask

    task automatic test_simultaneous();
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h8000, 32'h0, $urandom);
        vectors++;
        if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b01 || bus.mem_addr_o !== 32'h8000) begin
            miscompares++;
            $display("[TB] FAIL simultaneous_grant: got gnt=%b%b addr=%h expected 01 00008000",
                     bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o);
        end
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D);
        vectors++;
        if (bus.data_rvalid_o !== 1'b1 || bus.data_rdata_o !== 32'hCAFEF00D ||
            bus.instr_rvalid_o !== 1'b0 || bus.instr_rdata_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL simultaneous_resp: got drv=%b drd=%h irv=%b ird=%h expected 1 cafef00d 0 0",
                     bus.data_rvalid_o, bus.data_rdata_o, bus.instr_rvalid_o, bus.instr_rdata_o);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [1:0] want;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
        step();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h9000 + 32'(c), 32'h0, $urandom);
            want = (c == LIMIT) ? 2'b10 : 2'b01;
            vectors++;
            if ({bus.instr_gnt_o, bus.data_gnt_o} !== want) begin
                miscompares++;
                $display("[TB] FAIL starvation_cycle%0d: got gnt=%b%b expected %b",
                         c, bus.instr_gnt_o, bus.data_gnt_o, want);
            end
            step();
        end
    endtask

    task automatic test_write();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, $urandom);
        vectors++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.data_gnt_o} !== 3'b111 ||
            bus.mem_addr_o !== 32'h40 || bus.mem_wdata_o !== 32'h12345678) begin
            miscompares++;
            $display("[TB] FAIL write_drive: got req/we/gnt=%b%b%b addr=%h wdata=%h expected 111 00000040 12345678",
                     bus.mem_req_o, bus.mem_we_o, bus.data_gnt_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
        vectors++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL write_no_rvalid: got rvalid=%b%b expected 00",
                     bus.instr_rvalid_o, bus.data_rvalid_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
        vectors++;
        if (bus.instr_gnt_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_instr_gnt: got %b expected 1", bus.instr_gnt_o);
        end
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h11111111);
        vectors++;
        if ({bus.instr_rvalid_o, bus.data_gnt_o, bus.data_rvalid_o} !== 3'b110 ||
            bus.instr_rdata_o !== 32'h11111111 || bus.mem_addr_o !== 32'h10) begin
            miscompares++;
            $display("[TB] FAIL b2b_cycle1: got irv/dgt/drv=%b%b%b ird=%h addr=%h expected 110 11111111 00000010",
                     bus.instr_rvalid_o, bus.data_gnt_o, bus.data_rvalid_o, bus.instr_rdata_o, bus.mem_addr_o);
        end
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h22222222);
        vectors++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b01 || bus.data_rdata_o !== 32'h22222222) begin
            miscompares++;
            $display("[TB] FAIL b2b_cycle2: got irv/drv=%b%b drd=%h expected 01 22222222",
                     bus.instr_rvalid_o, bus.data_rvalid_o, bus.data_rdata_o);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
        vectors++;
        if (bus.instr_gnt_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_gnt: got %b expected 1", bus.instr_gnt_o);
        end
        step();
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h304, 1'b1, 1'b0, 32'h50, 32'h0, 32'h5A5A5A5A);
        vectors++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_gnt_o, bus.data_gnt_o, bus.mem_req_o} !== 5'b0 ||
            bus.instr_rdata_o !== 32'h0 || bus.mem_addr_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_during: got irv/drv/igt/dgt/mreq=%b%b%b%b%b ird=%h addr=%h expected all 0",
                     bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_gnt_o, bus.data_gnt_o,
                     bus.mem_req_o, bus.instr_rdata_o, bus.mem_addr_o);
        end
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5A5A5A5A);
        vectors++;
        if (bus.instr_rvalid_o !== 1'b0 || bus.instr_rdata_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_after: got irv=%b ird=%h expected 0 0",
                     bus.instr_rvalid_o, bus.instr_rdata_o);
        end
`ifdef ARB_PERF_CNT_EN
        vectors++;
        if (conflict_cnt !== 32'h0 || starve_evt_cnt !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_perf: got conflict=%0d starve=%0d expected 0 0",
                     conflict_cnt, starve_evt_cnt);
        end
`endif
        step();
    endtask

    task automatic test_random();
        logic [133:0] got, want;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0, $urandom_range(0, 1),
                          $urandom, $urandom, $urandom);
            got  = {bus.instr_gnt_o, bus.data_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o,
                    bus.mem_wdata_o, bus.instr_rvalid_o, bus.instr_rdata_o, bus.data_rvalid_o, bus.data_rdata_o};
            want = {e_igt, e_dgt, e_mreq, e_mwe, e_maddr, e_mwdata, e_irv, e_ird, e_drv, e_drd};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", c, got, want);
            end
`ifdef ARB_PERF_CNT_EN
            vectors++;
            if (conflict_cnt !== (rst_n ? 32'(m_conflicts) : 32'h0) ||
                starve_evt_cnt !== (rst_n ? 32'(m_starve_ev) : 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL random_perf%0d: got conflict=%0d starve=%0d expected %0d %0d",
                         c, conflict_cnt, starve_evt_cnt, rst_n ? m_conflicts : 0, rst_n ? m_starve_ev : 0);
            end
`endif
            step();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_instr_read();
        test_simultaneous();
        test_starvation();
        test_write();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
